// File: rtl/veri_yolu_birimi_ardisik_pkg.sv
// Shared access-size codes and the per-read metadata carried through the pending FIFO.
package veri_yolu_birimi_ardisik_pkg;

    localparam logic [1:0] BOYUT_BAYT     = 2'd0;
    localparam logic [1:0] BOYUT_YARIM    = 2'd1;
    localparam logic [1:0] BOYUT_KELIME   = 2'd2;
    localparam logic [1:0] BOYUT_GECERSIZ = 2'd3;

    // Offset (2) + size (2) + signed flag (1)
    localparam int unsigned META_BIT = 2 + 2 + 1;

    typedef struct packed {
        logic [1:0] ofs;
        logic [1:0] boyut;
        logic       isaretli;
    } meta_t;

endpackage

// File: rtl/veri_yolu_birimi_ardisik_if.sv
// Request bundle from the memory-stage issue logic and the L1 data controller channel.
// master: the load/store unit; slave: the issue logic together with the L1 side.
interface veri_yolu_birimi_ardisik_if #(
    parameter int unsigned ADRES_BIT = 32,
    parameter int unsigned VERI_BIT  = 32
);
    localparam int unsigned VERI_BYTE = VERI_BIT / 8;

    logic                 bib_istek_gecerli;
    logic                 bib_istek_hazir;
    logic                 bib_istek_yaz;
    logic [ADRES_BIT-1:0] bib_istek_adres;
    logic [VERI_BIT-1:0]  bib_istek_veri;
    logic [1:0]           bib_istek_boyut;
    logic                 bib_istek_isaretli;

    logic                 port_istek_gecerli;
    logic                 port_istek_hazir;
    logic [ADRES_BIT-1:0] port_istek_adres;
    logic                 port_istek_yaz;
    logic [VERI_BIT-1:0]  port_istek_veri;
    logic [VERI_BYTE-1:0] port_istek_maske;
    logic [VERI_BIT-1:0]  port_veri;
    logic                 port_veri_gecerli;
    logic                 port_veri_hazir;

    modport master (
        input  bib_istek_gecerli, bib_istek_yaz, bib_istek_adres, bib_istek_veri,
        input  bib_istek_boyut, bib_istek_isaretli,
        output bib_istek_hazir,
        output port_istek_gecerli, port_istek_adres, port_istek_yaz, port_istek_veri,
        output port_istek_maske, port_veri_hazir,
        input  port_istek_hazir, port_veri, port_veri_gecerli
    );

    modport slave (
        output bib_istek_gecerli, bib_istek_yaz, bib_istek_adres, bib_istek_veri,
        output bib_istek_boyut, bib_istek_isaretli,
        input  bib_istek_hazir,
        input  port_istek_gecerli, port_istek_adres, port_istek_yaz, port_istek_veri,
        input  port_istek_maske, port_veri_hazir,
        output port_istek_hazir, port_veri, port_veri_gecerli
    );

endinterface

// File: rtl/vyb_bekleyen_fifo.sv
// Small synchronous FIFO for in-order trackers; combinational read of the head entry.
module vyb_bekleyen_fifo #(
    parameter int unsigned GENISLIK = 5,
    parameter int unsigned DERINLIK = 4,
    localparam int unsigned PTR_BIT = $clog2(DERINLIK)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                yaz_i,
    input  logic [GENISLIK-1:0] veri_i,
    input  logic                oku_i,
    output logic [GENISLIK-1:0] veri_o,
    output logic                dolu_o,
    output logic                bos_o,
    output logic [PTR_BIT:0]    sayac_o
);

    logic [GENISLIK-1:0] mem_q [DERINLIK];
    logic [PTR_BIT-1:0]  yaz_ptr_q;
    logic [PTR_BIT-1:0]  oku_ptr_q;
    logic [PTR_BIT:0]    sayac_q;
    logic                yaz_et;
    logic                oku_et;

    assign dolu_o  = (sayac_q == (PTR_BIT+1)'(DERINLIK));
    assign bos_o   = (sayac_q == '0);
    assign sayac_o = sayac_q;
    assign veri_o  = mem_q[oku_ptr_q];
    assign yaz_et  = yaz_i && !dolu_o;
    assign oku_et  = oku_i && !bos_o;

    // Storage, power-of-two pointers that wrap naturally, and occupancy count
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayac_q   <= '0;
            for (int i = 0; i < int'(DERINLIK); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (yaz_et) begin
                mem_q[yaz_ptr_q] <= veri_i;
                yaz_ptr_q        <= yaz_ptr_q + PTR_BIT'(1);
            end
            if (oku_et) begin
                oku_ptr_q <= oku_ptr_q + PTR_BIT'(1);
            end
            if (yaz_et && !oku_et) begin
                sayac_q <= sayac_q + (PTR_BIT+1)'(1);
            end else if (!yaz_et && oku_et) begin
                sayac_q <= sayac_q - (PTR_BIT+1)'(1);
            end
        end
    end

endmodule

// File: rtl/veri_yolu_birimi_ardisik.sv
// Pipelined load/store port: one-entry issue register towards L1, in-order read tracking,
// store lane formatting and load extraction with sign/zero extension.
module veri_yolu_birimi_ardisik
    import veri_yolu_birimi_ardisik_pkg::*;
#(
    parameter int unsigned ADRES_BIT         = 32,
    parameter int unsigned VERI_BIT          = 32,
    parameter int unsigned BEKLEYEN_DERINLIK = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    veri_yolu_birimi_ardisik_if.master vy,
    output logic [VERI_BIT-1:0]  bellek_veri_o,
    output logic                 bellek_gecerli_o,
    output logic                 bellek_yaz_tamam_o,
    output logic                 bellek_hata_o,
    output logic [ADRES_BIT-1:0] bellek_hata_adres_o,
    output logic                 bos_o
);

    localparam int unsigned VERI_BYTE = VERI_BIT / 8;
    localparam int unsigned SAYAC_BIT = $clog2(BEKLEYEN_DERINLIK) + 1;

    function automatic logic hizali_mi(input logic [1:0] boyut, input logic [1:0] ofs);
        case (boyut)
            BOYUT_BAYT:     return 1'b1;
            BOYUT_YARIM:    return !ofs[0];
            BOYUT_KELIME:   return (ofs == 2'd0);
            BOYUT_GECERSIZ: return 1'b0;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [VERI_BYTE-1:0] maske_uret(input logic [1:0] boyut,
                                                       input logic [1:0] ofs);
        logic [VERI_BYTE-1:0] taban;
        case (boyut)
            BOYUT_BAYT:  taban = VERI_BYTE'(1);
            BOYUT_YARIM: taban = VERI_BYTE'(3);
            default:     taban = '1;
        endcase
        return taban << ofs;
    endfunction

    function automatic logic [VERI_BIT-1:0] yukle_ayikla(input logic [VERI_BIT-1:0] ham,
                                                        input meta_t m);
        logic [VERI_BIT-1:0] kay;
        kay = ham >> {m.ofs, 3'b000};
        case (m.boyut)
            BOYUT_BAYT:  return {{(VERI_BIT-8){m.isaretli & kay[7]}}, kay[7:0]};
            BOYUT_YARIM: return {{(VERI_BIT-16){m.isaretli & kay[15]}}, kay[15:0]};
            default:     return kay;
        endcase
    endfunction

    logic                 dolu_q, dolu_d;
    logic [ADRES_BIT-1:0] adres_q, adres_d;
    logic                 yaz_q, yaz_d;
    logic [VERI_BIT-1:0]  veri_q, veri_d;
    logic [VERI_BYTE-1:0] maske_q, maske_d;

    logic                 hata_q, yaz_tamam_q, gecerli_q;
    logic [ADRES_BIT-1:0] hata_adres_q;
    logic [VERI_BIT-1:0]  sonuc_q;

    logic                 port_el, bib_hazir, kabul, hizali, yukle_kabul, cevap;
    logic [1:0]           ofs;
    logic                 fifo_dolu, fifo_bos;
    logic [SAYAC_BIT-1:0] sayac;
    meta_t                meta_yaz, meta_oku;

    assign ofs         = vy.bib_istek_adres[1:0];
    assign hizali      = hizali_mi(vy.bib_istek_boyut, ofs);
    assign port_el     = dolu_q && vy.port_istek_hazir;
    // A full tracker also stalls stores so responses never need reordering
    assign bib_hazir   = (!dolu_q || port_el) && !fifo_dolu;
    assign kabul       = vy.bib_istek_gecerli && bib_hazir;
    assign yukle_kabul = kabul && hizali && !vy.bib_istek_yaz;
    assign cevap       = vy.port_veri_gecerli && !fifo_bos;
    assign meta_yaz    = '{ofs: ofs, boyut: vy.bib_istek_boyut,
                           isaretli: vy.bib_istek_isaretli};

    vyb_bekleyen_fifo #(
        .GENISLIK (META_BIT),
        .DERINLIK (BEKLEYEN_DERINLIK)
    ) u_bekleyen (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .yaz_i   (yukle_kabul),
        .veri_i  (meta_yaz),
        .oku_i   (cevap),
        .veri_o  (meta_oku),
        .dolu_o  (fifo_dolu),
        .bos_o   (fifo_bos),
        .sayac_o (sayac)
    );

    // Issue register next state: drain on handshake, refill on aligned accept
    always_comb begin
        dolu_d  = dolu_q;
        adres_d = adres_q;
        yaz_d   = yaz_q;
        veri_d  = veri_q;
        maske_d = maske_q;
        if (port_el) begin
            dolu_d = 1'b0;
        end
        if (kabul && hizali) begin
            dolu_d  = 1'b1;
            adres_d = {vy.bib_istek_adres[ADRES_BIT-1:2], 2'b00};
            yaz_d   = vy.bib_istek_yaz;
            if (vy.bib_istek_yaz) begin
                veri_d  = vy.bib_istek_veri << {ofs, 3'b000};
                maske_d = maske_uret(vy.bib_istek_boyut, ofs);
            end else begin
                veri_d  = '0;
                maske_d = '1;
            end
        end
    end

    // Issue register and one-cycle status/result outputs
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dolu_q       <= 1'b0;
            adres_q      <= '0;
            yaz_q        <= 1'b0;
            veri_q       <= '0;
            maske_q      <= '0;
            hata_q       <= 1'b0;
            hata_adres_q <= '0;
            yaz_tamam_q  <= 1'b0;
            gecerli_q    <= 1'b0;
            sonuc_q      <= '0;
        end else begin
            dolu_q      <= dolu_d;
            adres_q     <= adres_d;
            yaz_q       <= yaz_d;
            veri_q      <= veri_d;
            maske_q     <= maske_d;
            hata_q      <= kabul && !hizali;
            yaz_tamam_q <= port_el && yaz_q;
            gecerli_q   <= cevap;
            if (kabul && !hizali) begin
                hata_adres_q <= vy.bib_istek_adres;
            end
            if (cevap) begin
                sonuc_q <= yukle_ayikla(vy.port_veri, meta_oku);
            end
        end
    end

    assign vy.bib_istek_hazir    = bib_hazir;
    assign vy.port_istek_gecerli = dolu_q;
    assign vy.port_istek_adres   = adres_q;
    assign vy.port_istek_yaz     = yaz_q;
    assign vy.port_istek_veri    = veri_q;
    assign vy.port_istek_maske   = maske_q;
    assign vy.port_veri_hazir    = !fifo_bos;

    assign bellek_veri_o       = sonuc_q;
    assign bellek_gecerli_o    = gecerli_q;
    assign bellek_yaz_tamam_o  = yaz_tamam_q;
    assign bellek_hata_o       = hata_q;
    assign bellek_hata_adres_o = hata_adres_q;
    assign bos_o               = !dolu_q && (sayac == '0);

endmodule

// File: tb/tb_veri_yolu_birimi_ardisik.sv
// Directed bench for the pipelined load/store port with hand-computed expectations.
module tb_veri_yolu_birimi_ardisik;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] bellek_veri;
    logic        bellek_gecerli, bellek_yaz_tamam, bellek_hata, bos;
    logic [31:0] bellek_hata_adres;

    int unsigned gecen  = 0;
    int unsigned toplam = 0;

    always #5 clk_i = ~clk_i;

    veri_yolu_birimi_ardisik_if #(.ADRES_BIT(32), .VERI_BIT(32)) vy ();

    veri_yolu_birimi_ardisik #(
        .ADRES_BIT         (32),
        .VERI_BIT          (32),
        .BEKLEYEN_DERINLIK (4)
    ) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .vy                  (vy),
        .bellek_veri_o       (bellek_veri),
        .bellek_gecerli_o    (bellek_gecerli),
        .bellek_yaz_tamam_o  (bellek_yaz_tamam),
        .bellek_hata_o       (bellek_hata),
        .bellek_hata_adres_o (bellek_hata_adres),
        .bos_o               (bos)
    );

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        toplam++;
        assert (gozlenen === beklenen) begin
            gecen++;
        end else begin
            $error("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic saat();
        @(posedge clk_i);
        #1;
    endtask

    task automatic istek(input logic yaz, input logic [31:0] adres, input logic [31:0] veri,
                         input logic [1:0] boyut, input logic isaretli);
        vy.bib_istek_gecerli  = 1'b1;
        vy.bib_istek_yaz      = yaz;
        vy.bib_istek_adres    = adres;
        vy.bib_istek_veri     = veri;
        vy.bib_istek_boyut    = boyut;
        vy.bib_istek_isaretli = isaretli;
    endtask

    // One load from accept through L1 response to the extended result
    task automatic yukle_tur(input string t, input logic [31:0] adres, input logic [1:0] boyut,
                             input logic isaretli, input logic [31:0] l1,
                             input logic [31:0] port_adres, input logic [31:0] bek);
        vy.port_istek_hazir = 1'b1;
        istek(1'b0, adres, 32'h0, boyut, isaretli);
        #1 kontrol({t, "_bib_hazir"}, vy.bib_istek_hazir, 1);
        saat();
        vy.bib_istek_gecerli = 1'b0;
        kontrol({t, "_port_gecerli"}, vy.port_istek_gecerli, 1);
        kontrol({t, "_port_adres"}, vy.port_istek_adres, port_adres);
        kontrol({t, "_port_maske"}, vy.port_istek_maske, 32'hF);
        kontrol({t, "_port_veri"}, vy.port_istek_veri, 32'h0);
        kontrol({t, "_port_yaz"}, vy.port_istek_yaz, 0);
        saat();
        vy.port_veri         = l1;
        vy.port_veri_gecerli = 1'b1;
        #1 kontrol({t, "_veri_hazir"}, vy.port_veri_hazir, 1);
        saat();
        vy.port_veri_gecerli = 1'b0;
        kontrol({t, "_gecerli"}, bellek_gecerli, 1);
        kontrol({t, "_sonuc"}, bellek_veri, bek);
        saat();
        kontrol({t, "_gecerli_tek"}, bellek_gecerli, 0);
        kontrol({t, "_sonuc_tut"}, bellek_veri, bek);
    endtask

    initial begin
        vy.bib_istek_gecerli  = 1'b0;
        vy.bib_istek_yaz      = 1'b0;
        vy.bib_istek_adres    = '0;
        vy.bib_istek_veri     = '0;
        vy.bib_istek_boyut    = '0;
        vy.bib_istek_isaretli = 1'b0;
        vy.port_istek_hazir   = 1'b0;
        vy.port_veri          = '0;
        vy.port_veri_gecerli  = 1'b0;

        // Reset state
        saat();
        saat();
        kontrol("rst_port_gecerli", vy.port_istek_gecerli, 0);
        kontrol("rst_veri_hazir", vy.port_veri_hazir, 0);
        kontrol("rst_bellek_gecerli", bellek_gecerli, 0);
        kontrol("rst_bellek_veri", bellek_veri, 0);
        kontrol("rst_yaz_tamam", bellek_yaz_tamam, 0);
        kontrol("rst_hata", bellek_hata, 0);
        kontrol("rst_hata_adres", bellek_hata_adres, 0);
        kontrol("rst_bos", bos, 1);
        rstn_i = 1'b1;
        saat();

        // Byte store at offset 3
        vy.port_istek_hazir = 1'b1;
        istek(1'b1, 32'h1003, 32'hAB, 2'd0, 1'b0);
        #1 kontrol("bst_bib_hazir", vy.bib_istek_hazir, 1);
        saat();
        vy.bib_istek_gecerli = 1'b0;
        kontrol("bst_port_gecerli", vy.port_istek_gecerli, 1);
        kontrol("bst_port_adres", vy.port_istek_adres, 32'h1000);
        kontrol("bst_port_maske", vy.port_istek_maske, 32'h8);
        kontrol("bst_port_veri", vy.port_istek_veri, 32'hAB00_0000);
        kontrol("bst_port_yaz", vy.port_istek_yaz, 1);
        kontrol("bst_tamam_erken", bellek_yaz_tamam, 0);
        saat();
        kontrol("bst_tamam", bellek_yaz_tamam, 1);
        kontrol("bst_port_bos", vy.port_istek_gecerli, 0);
        saat();
        kontrol("bst_tamam_tek", bellek_yaz_tamam, 0);

        // Signed and unsigned half loads at offset 2
        yukle_tur("hs", 32'h2002, 2'd1, 1'b1, 32'h8001_1234, 32'h2000, 32'hFFFF_8001);
        yukle_tur("hu", 32'h2002, 2'd1, 1'b0, 32'h8001_1234, 32'h2000, 32'h0000_8001);

        // Misaligned word and illegal size
        istek(1'b0, 32'h3001, 32'h0, 2'd2, 1'b0);
        #1 kontrol("mis_bib_hazir", vy.bib_istek_hazir, 1);
        saat();
        vy.bib_istek_gecerli = 1'b0;
        kontrol("mis_hata", bellek_hata, 1);
        kontrol("mis_hata_adres", bellek_hata_adres, 32'h3001);
        kontrol("mis_port_gecerli", vy.port_istek_gecerli, 0);
        kontrol("mis_sayac", vy.port_veri_hazir, 0);
        saat();
        kontrol("mis_hata_tek", bellek_hata, 0);
        kontrol("mis_bos", bos, 1);
        istek(1'b1, 32'h3000, 32'h55, 2'd3, 1'b0);
        saat();
        vy.bib_istek_gecerli = 1'b0;
        kontrol("gcs_hata", bellek_hata, 1);
        kontrol("gcs_hata_adres", bellek_hata_adres, 32'h3000);
        kontrol("gcs_port_gecerli", vy.port_istek_gecerli, 0);
        saat();

        // Outstanding limit: four loads in flight, fifth held off until one drains
        for (int i = 0; i < 4; i++) begin
            istek(1'b0, 32'h4000 + i, 32'h0, 2'd0, 1'b0);
            #1 kontrol("lim_kabul", vy.bib_istek_hazir, 1);
            saat();
        end
        istek(1'b0, 32'h4004, 32'h0, 2'd0, 1'b0);
        #1 kontrol("lim_dolu_hazir", vy.bib_istek_hazir, 0);
        saat();
        kontrol("lim_son_verildi", vy.port_istek_gecerli, 0);
        kontrol("lim_veri_hazir", vy.port_veri_hazir, 1);
        vy.port_veri         = 32'h1122_3344;
        vy.port_veri_gecerli = 1'b1;
        #1 kontrol("lim_hala_dolu", vy.bib_istek_hazir, 0);
        saat();
        kontrol("lim_s0_gecerli", bellek_gecerli, 1);
        kontrol("lim_s0", bellek_veri, 32'h44);
        #1 kontrol("lim_yeniden_kabul", vy.bib_istek_hazir, 1);
        saat();
        vy.bib_istek_gecerli = 1'b0;
        kontrol("lim_s1", bellek_veri, 32'h33);
        kontrol("lim_l4_adres", vy.port_istek_adres, 32'h4004);
        saat();
        kontrol("lim_s2", bellek_veri, 32'h22);
        saat();
        kontrol("lim_s3", bellek_veri, 32'h11);
        saat();
        vy.port_veri_gecerli = 1'b0;
        kontrol("lim_s4", bellek_veri, 32'h44);
        kontrol("lim_s4_gecerli", bellek_gecerli, 1);
        saat();
        kontrol("lim_bitti_gecerli", bellek_gecerli, 0);
        kontrol("lim_bos", bos, 1);

        // Backpressure: L1 stalls three cycles with a second store waiting
        vy.port_istek_hazir = 1'b0;
        istek(1'b1, 32'h5002, 32'hBEEF, 2'd1, 1'b0);
        #1 kontrol("bp_kabul", vy.bib_istek_hazir, 1);
        saat();
        istek(1'b1, 32'h5004, 32'h1234_5678, 2'd2, 1'b0);
        #1 kontrol("bp_bib_durdu", vy.bib_istek_hazir, 0);
        for (int k = 0; k < 3; k++) begin
            kontrol("bp_gecerli", vy.port_istek_gecerli, 1);
            kontrol("bp_adres", vy.port_istek_adres, 32'h5000);
            kontrol("bp_maske", vy.port_istek_maske, 32'hC);
            kontrol("bp_veri", vy.port_istek_veri, 32'hBEEF_0000);
            kontrol("bp_tamam_yok", bellek_yaz_tamam, 0);
            saat();
        end
        vy.port_istek_hazir = 1'b1;
        #1 kontrol("bp_ikinci_kabul", vy.bib_istek_hazir, 1);
        saat();
        vy.bib_istek_gecerli = 1'b0;
        kontrol("bp_tamam1", bellek_yaz_tamam, 1);
        kontrol("bp2_gecerli", vy.port_istek_gecerli, 1);
        kontrol("bp2_adres", vy.port_istek_adres, 32'h5004);
        kontrol("bp2_maske", vy.port_istek_maske, 32'hF);
        kontrol("bp2_veri", vy.port_istek_veri, 32'h1234_5678);
        saat();
        kontrol("bp_tamam2", bellek_yaz_tamam, 1);
        kontrol("bp_cift_yok", vy.port_istek_gecerli, 0);
        saat();
        kontrol("bp_tamam_bitti", bellek_yaz_tamam, 0);

        // Reset with three reads outstanding
        for (int i = 0; i < 3; i++) begin
            istek(1'b0, 32'h6000 + 4 * i, 32'h0, 2'd2, 1'b0);
            saat();
        end
        vy.bib_istek_gecerli = 1'b0;
        saat();
        kontrol("rr_bekleyen", vy.port_veri_hazir, 1);
        kontrol("rr_bos_degil", bos, 0);
        kontrol("rr_onceki_sonuc", bellek_veri, 32'h44);
        rstn_i = 1'b0;
        saat();
        kontrol("rr_veri_hazir", vy.port_veri_hazir, 0);
        kontrol("rr_bos", bos, 1);
        kontrol("rr_port_gecerli", vy.port_istek_gecerli, 0);
        kontrol("rr_bellek_veri", bellek_veri, 0);
        kontrol("rr_bellek_gecerli", bellek_gecerli, 0);
        rstn_i = 1'b1;
        saat();
        yukle_tur("rw", 32'h6010, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h6010, 32'hCAFE_F00D);
        kontrol("rw_bos", bos, 1);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
